// File: rtl/intc_rst_vector_if.sv
// rtl/intc_rst_vector_if.sv - CPU-side bus bundle between the 8080 core and the RST vector controller
//
// Purpose : groups the interrupt handshake and the I/O port bus seen by intc_rst_vector.
// Signals :
//   int_req    controller -> CPU   interrupt request (CPU iint)
//   inta_rd    CPU -> controller   CPU is reading the interrupt opcode
//   vector     controller -> CPU   RST opcode for the data bus
//   vector_oe  controller -> CPU   tri-state enable for vector
//   io_wr      CPU -> controller   OUT write strobe
//   io_rd      CPU -> controller   IN read strobe
//   io_addr    CPU -> controller   I/O port address
//   wdata      CPU -> controller   OUT write data
//   rdata      controller -> CPU   IN read data
//   rdata_oe   controller -> CPU   tri-state enable for rdata
// Modports: master = CPU side, slave = controller side.

interface intc_rst_vector_if;
   logic       int_req;
   logic       inta_rd;
   logic [7:0] vector;
   logic       vector_oe;
   logic       io_wr;
   logic       io_rd;
   logic [7:0] io_addr;
   logic [7:0] wdata;
   logic [7:0] rdata;
   logic       rdata_oe;

   modport master (
      input  int_req, vector, vector_oe, rdata, rdata_oe,
      output inta_rd, io_wr, io_rd, io_addr, wdata
   );

   modport slave (
      output int_req, vector, vector_oe, rdata, rdata_oe,
      input  inta_rd, io_wr, io_rd, io_addr, wdata
   );
endinterface

// File: rtl/intc_rst_vector.sv
// rtl/intc_rst_vector.sv - 8080 interrupt controller supplying RST n opcodes during INTA
//
// Purpose : collects NUM_IRQ level sources, latches their rising edges into pending bits,
//           picks the lowest-index enabled pending source and drives RST (VECTOR_BASE+sel)
//           onto the data bus while the CPU performs its INTA read. Only the serviced
//           source is cleared, when inta_rd falls.
// Ports   :
//   clk   CPU clock
//   rst   asynchronous, active-high reset
//   irq   NUM_IRQ level sources; a rising edge is a request
//   bus   intc_rst_vector_if.slave (int_req, inta_rd, vector/vector_oe, io_* port bus)
// Config  : INTC_MASK_EN - when defined, OUT PORT_ADDR writes a per-source enable mask
//           (1 = enabled) and IN PORT_ADDR bit 7 flags a pending source that is masked.
//           When undefined the mask is fixed all ones and OUT writes are ignored.

module intc_rst_vector #(
   parameter int         NUM_IRQ     = 2,
   parameter int         VECTOR_BASE = 1,
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] PORT_ADDR   = 8'h06
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_IRQ-1:0]  irq,
   intc_rst_vector_if.slave    bus
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_ACK  = 1'b1
   } state_t;

   logic [NUM_IRQ-1:0] irq_s;
   logic [NUM_IRQ-1:0] prev_q, prev_d;
   logic [NUM_IRQ-1:0] edge_q, edge_d;
   logic [NUM_IRQ-1:0] pending_q, pending_d;
   logic [NUM_IRQ-1:0] mask;
   logic [NUM_IRQ-1:0] enabled;

   state_t     state_q;
   logic [2:0] sel_q;
   logic       spur_q;

   logic [2:0] prio_sel;
   logic       prio_hit;
   logic       ack_done;
   logic       port_hit;

   logic [2:0] vec_sel;
   logic       vec_hit;
   logic [2:0] vec_n;
   logic [7:0] rd_val;

   // ------------------------------------------------------------------
   // Input synchroniser chain (bypassed when sources are already in clk domain)
   // ------------------------------------------------------------------
   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign irq_s = irq;
      end else begin : g_sync
         logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] sync_q;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               sync_q <= '0;
            end else begin
               sync_q[0] <= irq;
               for (int k = 1; k < SYNC_STAGES; k++) begin
                  sync_q[k] <= sync_q[k-1];
               end
            end
         end

         assign irq_s = sync_q[SYNC_STAGES-1];
      end
   endgenerate

   // ------------------------------------------------------------------
   // Mask register
   // ------------------------------------------------------------------
   assign port_hit = (bus.io_addr == PORT_ADDR);

`ifdef INTC_MASK_EN
   logic [NUM_IRQ-1:0] mask_q, mask_d;

   always_comb begin
      mask_d = mask_q;
      if (bus.io_wr && port_hit) begin
         mask_d = bus.wdata[NUM_IRQ-1:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mask_q <= '1;
      end else begin
         mask_q <= mask_d;
      end
   end

   assign mask = mask_q;
`else
   assign mask = '1;
`endif

   // Upper wdata bits never reach a register; in the fixed-mask build the whole write path is idle.
   logic unused_wr;
   assign unused_wr = ^{bus.wdata, bus.io_wr};

   // ------------------------------------------------------------------
   // Edge detect and pending latch
   // ------------------------------------------------------------------
   // The edge flag is registered so a request lands in pending two cycles after
   // the synchronised level rises, independent of SYNC_STAGES.
   assign ack_done = (state_q == ST_ACK) && !bus.inta_rd && !spur_q;

   always_comb begin
      prev_d    = irq_s;
      edge_d    = irq_s & ~prev_q;
      pending_d = pending_q;
      if (ack_done) begin
         for (int i = 0; i < NUM_IRQ; i++) begin
            if (sel_q == 3'(i)) begin
               pending_d[i] = 1'b0;
            end
         end
      end
      // A fresh edge on the source being cleared is applied last so it is never lost.
      pending_d = pending_d | edge_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_q    <= '0;
         edge_q    <= '0;
         pending_q <= '0;
      end else begin
         prev_q    <= prev_d;
         edge_q    <= edge_d;
         pending_q <= pending_d;
      end
   end

   // ------------------------------------------------------------------
   // Priority: lowest index wins
   // ------------------------------------------------------------------
   always_comb begin
      enabled  = pending_q & mask;
      prio_sel = 3'd0;
      prio_hit = 1'b0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (enabled[i]) begin
            prio_sel = 3'(i);
            prio_hit = 1'b1;
         end
      end
   end

   assign bus.int_req = |enabled;

   // ------------------------------------------------------------------
   // Acknowledge FSM
   // ------------------------------------------------------------------
   // sel is frozen on the first INTA cycle so later edges cannot alter the opcode
   // mid-read; spur marks an acknowledge that found nothing to service.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         sel_q   <= 3'd0;
         spur_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.inta_rd) begin
                  state_q <= ST_ACK;
                  sel_q   <= prio_sel;
                  spur_q  <= ~prio_hit;
               end
            end
            ST_ACK: begin
               if (!bus.inta_rd) begin
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Vector output
   // ------------------------------------------------------------------
   always_comb begin
      if (state_q == ST_ACK) begin
         vec_sel = sel_q;
         vec_hit = ~spur_q;
      end else begin
         vec_sel = prio_sel;
         vec_hit = prio_hit;
      end
      vec_n = 3'(VECTOR_BASE) + vec_sel;
   end

   // Nothing to service reads as RST 7 (8'hFF), a harmless opcode on an idle bus.
   assign bus.vector    = vec_hit ? {2'b11, vec_n, 3'b111} : 8'hFF;
   assign bus.vector_oe = bus.inta_rd;

   // ------------------------------------------------------------------
   // Status readback
   // ------------------------------------------------------------------
   always_comb begin
      rd_val = 8'h00;
      for (int i = 0; i < NUM_IRQ; i++) begin
         rd_val[i] = pending_q[i];
      end
`ifdef INTC_MASK_EN
      rd_val[7] = rd_val[7] | (|(pending_q & ~mask));
`endif
   end

   assign bus.rdata_oe = bus.io_rd && port_hit;
   assign bus.rdata    = bus.rdata_oe ? rd_val : 8'h00;

endmodule

// File: tb/tb_intc_rst_vector.sv
// tb/tb_intc_rst_vector.sv - directed self-checking bench for intc_rst_vector

module tb_intc_rst_vector;

   localparam logic [7:0] PORT = 8'h06;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] irq = 2'b00;

   int n_checks = 0;
   int n_fail   = 0;

   intc_rst_vector_if bus ();

   intc_rst_vector #(
      .NUM_IRQ     (2),
      .VECTOR_BASE (1),
      .SYNC_STAGES (2),
      .PORT_ADDR   (PORT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .irq (irq),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic io_read(input logic [7:0] addr, output logic [7:0] d, output logic oe);
      bus.io_rd   = 1'b1;
      bus.io_addr = addr;
      #1;
      d  = bus.rdata;
      oe = bus.rdata_oe;
      bus.io_rd = 1'b0;
      #1;
   endtask

   task automatic io_write(input logic [7:0] d);
      bus.io_wr   = 1'b1;
      bus.io_addr = PORT;
      bus.wdata   = d;
      step(1);
      bus.io_wr = 1'b0;
   endtask

   task automatic test_reset;
      logic [7:0] d;
      logic       oe;
      rst = 1'b1;
      step(2);
      n_checks++; if (bus.int_req !== 1'b0) begin n_fail++; $display("FAIL rst_int_req: got %b exp 0", bus.int_req); end
      n_checks++; if (bus.vector !== 8'hFF) begin n_fail++; $display("FAIL rst_vector: got %h exp ff", bus.vector); end
      n_checks++; if (bus.vector_oe !== 1'b0) begin n_fail++; $display("FAIL rst_vector_oe: got %b exp 0", bus.vector_oe); end
      n_checks++; if (bus.rdata_oe !== 1'b0) begin n_fail++; $display("FAIL rst_rdata_oe: got %b exp 0", bus.rdata_oe); end
      rst = 1'b0;
      step(1);
      io_read(PORT, d, oe);
      n_checks++; if (d !== 8'h00 || oe !== 1'b1) begin n_fail++; $display("FAIL rst_readback: got %h/%b exp 00/1", d, oe); end
      io_read(8'h07, d, oe);
      n_checks++; if (oe !== 1'b0) begin n_fail++; $display("FAIL other_port_oe: got %b exp 0", oe); end
   endtask

   task automatic test_single;
      irq = 2'b10;
      for (int c = 1; c <= 3; c++) begin
         step(1);
         n_checks++; if (bus.int_req !== 1'b0) begin n_fail++; $display("FAIL t1_early_int_req c=%0d: got %b exp 0", c, bus.int_req); end
      end
      step(1);
      n_checks++; if (bus.int_req !== 1'b1) begin n_fail++; $display("FAIL t1_int_req_at4: got %b exp 1", bus.int_req); end
      bus.inta_rd = 1'b1;
      #1;
      n_checks++; if (bus.vector !== 8'hD7 || bus.vector_oe !== 1'b1) begin n_fail++; $display("FAIL t1_vector_idle: got %h/%b exp d7/1", bus.vector, bus.vector_oe); end
      step(1);
      n_checks++; if (bus.vector !== 8'hD7) begin n_fail++; $display("FAIL t1_vector_ack: got %h exp d7", bus.vector); end
      bus.inta_rd = 1'b0;
      #1;
      n_checks++; if (bus.vector_oe !== 1'b0) begin n_fail++; $display("FAIL t1_vector_oe_off: got %b exp 0", bus.vector_oe); end
      step(1);
      n_checks++; if (bus.int_req !== 1'b0) begin n_fail++; $display("FAIL t1_int_req_cleared: got %b exp 0", bus.int_req); end
      // level held high must not re-request
      step(5);
      n_checks++; if (bus.int_req !== 1'b0) begin n_fail++; $display("FAIL t1_level_no_retrigger: got %b exp 0", bus.int_req); end
      irq = 2'b00;
      step(4);
   endtask

   task automatic test_back_to_back;
      logic [7:0] d;
      logic       oe;
      irq = 2'b11;
      step(4);
      n_checks++; if (bus.int_req !== 1'b1) begin n_fail++; $display("FAIL t2_int_req: got %b exp 1", bus.int_req); end
      io_read(PORT, d, oe);
      n_checks++; if (d !== 8'h03) begin n_fail++; $display("FAIL t2_pending_both: got %h exp 03", d); end
      bus.inta_rd = 1'b1;
      step(1);
      n_checks++; if (bus.vector !== 8'hCF) begin n_fail++; $display("FAIL t2_first_vector: got %h exp cf", bus.vector); end
      bus.inta_rd = 1'b0;
      step(1);
      n_checks++; if (bus.int_req !== 1'b1) begin n_fail++; $display("FAIL t2_int_req_held: got %b exp 1", bus.int_req); end
      io_read(PORT, d, oe);
      n_checks++; if (d !== 8'h02) begin n_fail++; $display("FAIL t2_pending_after_first: got %h exp 02", d); end
      bus.inta_rd = 1'b1;
      step(1);
      n_checks++; if (bus.vector !== 8'hD7) begin n_fail++; $display("FAIL t2_second_vector: got %h exp d7", bus.vector); end
      bus.inta_rd = 1'b0;
      step(1);
      n_checks++; if (bus.int_req !== 1'b0) begin n_fail++; $display("FAIL t2_int_req_done: got %b exp 0", bus.int_req); end
      irq = 2'b00;
      step(4);
   endtask

   task automatic test_set_wins;
      logic [7:0] d;
      logic       oe;
      irq = 2'b01;
      step(4);
      irq = 2'b00;
      step(4);
      n_checks++; if (bus.int_req !== 1'b1) begin n_fail++; $display("FAIL t3_pre_int_req: got %b exp 1", bus.int_req); end
      irq = 2'b01;        // edge_q will be high for the edge at which the ack ends
      step(1);
      bus.inta_rd = 1'b1;
      step(1);
      n_checks++; if (bus.vector !== 8'hCF) begin n_fail++; $display("FAIL t3_vector: got %h exp cf", bus.vector); end
      step(1);
      bus.inta_rd = 1'b0;
      step(1);
      n_checks++; if (bus.int_req !== 1'b1) begin n_fail++; $display("FAIL t3_set_wins_int_req: got %b exp 1", bus.int_req); end
      io_read(PORT, d, oe);
      n_checks++; if (d !== 8'h01) begin n_fail++; $display("FAIL t3_set_wins_pending: got %h exp 01", d); end
      bus.inta_rd = 1'b1;
      step(1);
      bus.inta_rd = 1'b0;
      step(1);
      n_checks++; if (bus.int_req !== 1'b0) begin n_fail++; $display("FAIL t3_cleanup: got %b exp 0", bus.int_req); end
      irq = 2'b00;
      step(4);
   endtask

   task automatic test_spurious;
      logic [7:0] d;
      logic       oe;
      bus.inta_rd = 1'b1;
      #1;
      n_checks++; if (bus.vector !== 8'hFF) begin n_fail++; $display("FAIL t4_vector_idle: got %h exp ff", bus.vector); end
      step(1);
      n_checks++; if (bus.vector !== 8'hFF) begin n_fail++; $display("FAIL t4_vector_ack: got %h exp ff", bus.vector); end
      bus.inta_rd = 1'b0;
      step(1);
      io_read(PORT, d, oe);
      n_checks++; if (d !== 8'h00 || bus.int_req !== 1'b0) begin n_fail++; $display("FAIL t4_pending: got %h/%b exp 00/0", d, bus.int_req); end
      // FSM back in IDLE: a new request is serviced normally
      irq = 2'b10;
      step(4);
      bus.inta_rd = 1'b1;
      step(1);
      n_checks++; if (bus.vector !== 8'hD7) begin n_fail++; $display("FAIL t4_after_spurious: got %h exp d7", bus.vector); end
      bus.inta_rd = 1'b0;
      step(1);
      irq = 2'b00;
      step(4);
   endtask

   task automatic test_mask;
      logic [7:0] d;
      logic       oe;
      io_write(8'h02);     // enable only source 1
      irq = 2'b01;
      step(4);
`ifdef INTC_MASK_EN
      n_checks++; if (bus.int_req !== 1'b0) begin n_fail++; $display("FAIL t5_masked_int_req: got %b exp 0", bus.int_req); end
      io_read(PORT, d, oe);
      n_checks++; if (d !== 8'h81) begin n_fail++; $display("FAIL t5_masked_readback: got %h exp 81", d); end
      io_write(8'h03);
      n_checks++; if (bus.int_req !== 1'b1) begin n_fail++; $display("FAIL t5_unmask_int_req: got %b exp 1", bus.int_req); end
`else
      n_checks++; if (bus.int_req !== 1'b1) begin n_fail++; $display("FAIL t5_nomask_int_req: got %b exp 1", bus.int_req); end
      io_read(PORT, d, oe);
      n_checks++; if (d !== 8'h01) begin n_fail++; $display("FAIL t5_nomask_readback: got %h exp 01", d); end
`endif
      bus.inta_rd = 1'b1;
      step(1);
      n_checks++; if (bus.vector !== 8'hCF) begin n_fail++; $display("FAIL t5_vector: got %h exp cf", bus.vector); end
      bus.inta_rd = 1'b0;
      step(1);
      irq = 2'b00;
      step(4);
   endtask

   task automatic test_reset_in_ack;
      logic [7:0] d;
      logic       oe;
      irq = 2'b01;
      step(4);
      bus.inta_rd = 1'b1;
      step(1);
      #2;
      rst = 1'b1;
      #1;
      n_checks++; if (bus.int_req !== 1'b0) begin n_fail++; $display("FAIL t6_int_req: got %b exp 0", bus.int_req); end
      n_checks++; if (bus.vector !== 8'hFF) begin n_fail++; $display("FAIL t6_vector_idle: got %h exp ff", bus.vector); end
      n_checks++; if (bus.vector_oe !== 1'b1) begin n_fail++; $display("FAIL t6_vector_oe_hi: got %b exp 1", bus.vector_oe); end
      bus.inta_rd = 1'b0;
      #1;
      n_checks++; if (bus.vector_oe !== 1'b0) begin n_fail++; $display("FAIL t6_vector_oe_lo: got %b exp 0", bus.vector_oe); end
      step(1);
      irq = 2'b00;
      rst = 1'b0;
      step(1);
      io_read(PORT, d, oe);
      n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL t6_pending: got %h exp 00", d); end
   endtask

   initial begin
      bus.inta_rd = 1'b0;
      bus.io_wr   = 1'b0;
      bus.io_rd   = 1'b0;
      bus.io_addr = 8'h00;
      bus.wdata   = 8'h00;
      test_reset();
      test_single();
      test_back_to_back();
      test_set_wins();
      test_spurious();
      test_mask();
      test_reset_in_ack();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
